// File: rtl/mod_updown_counter.sv
// Programmable-modulus up/down counter with wrap/saturate modes and event pulses.
// Optional enable prescaler is built when CNT_PRESCALE_EN is defined.
module mod_updown_counter #(
  parameter int WIDTH       = 4,
  parameter int RESET_VALUE = 0,
  parameter int PRESCALE    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_limit,
  output logic             at_zero,
  output logic             wrap_pulse,
  output logic             sat_hit
);

  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VALUE);

  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be >= 1");
  end
  if (PRESCALE < 1) begin : g_bad_pre
    $error("PRESCALE must be >= 1");
  end

  logic step;

`ifdef CNT_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PTOP = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;
  logic          ptick;

  assign ptick = (pcnt == PTOP);

  // en=0 freezes the prescaler phase; load restarts it
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (load) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= ptick ? '0 : pcnt + PW'(1);
    end
  end

  assign step = en & ~load & ptick;
`else
  assign step = en & ~load;
`endif

  logic below;
  logic is_zero;
  logic inc;
  logic ovf;
  logic dec;
  logic unf;

  assign below   = (count < limit);
  assign is_zero = (count == '0);

  assign inc = step &  up &  below;
  assign ovf = step &  up & ~below;
  assign dec = step & ~up & ~is_zero;
  assign unf = step & ~up &  is_zero;

  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  logic             sat_d;

  always_comb begin
    count_d = count;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    unique case (1'b1)
      load: begin
        count_d = load_val;
      end
      inc: begin
        count_d = count + WIDTH'(1);
      end
      ovf: begin
        // clamp also pulls an out-of-range count back to limit
        if (sat_mode) begin
          count_d = limit;
          sat_d   = 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end
      dec: begin
        count_d = count - WIDTH'(1);
      end
      unf: begin
        if (sat_mode) begin
          sat_d   = 1'b1;
        end else begin
          count_d = limit;
          wrap_d  = 1'b1;
        end
      end
      default: begin
        count_d = count;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= RST;
      wrap_pulse <= 1'b0;
      sat_hit    <= 1'b0;
    end else begin
      count      <= count_d;
      wrap_pulse <= wrap_d;
      sat_hit    <= sat_d;
    end
  end

  assign at_limit = (count == limit);
  assign at_zero  = is_zero;

endmodule
